// File: rtl/meter_countdown.sv
// Parking-meter time core: remaining seconds, coin/preset update, 1 Hz countdown, BCD display feed.
// Optional METER_BUTTON_SYNC_EN: synchronise and edge-detect the add_*/set_* buttons.
//
// BCD converter states:
//   state | meaning
//   IDLE  | wait for secs to differ from the last latched source
//   SHIFT | 14 double-dabble steps on the latched source
//   DONE  | publish result to time_bcd, raise bcd_valid
module meter_countdown #(
    parameter int unsigned MAX_SECS   = 9999,
    parameter int unsigned LOW_THRESH = 180,
    parameter int unsigned PRESET_A   = 10,
    parameter int unsigned PRESET_B   = 205
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1hz,
    input  logic        blink_lvl,
    input  logic        add_60,
    input  logic        add_120,
    input  logic        add_180,
    input  logic        add_300,
    input  logic        set_a,
    input  logic        set_b,
    output logic [13:0] secs,
    output logic [15:0] time_bcd,
    output logic        digits_on,
    output logic        expired,
    output logic        bcd_valid
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

    logic [5:0]  btn_raw;
    logic [5:0]  btn_act;
    logic        tick_s, tick_d, blink_s;
    logic        strobe;
    logic        dec;
    logic [14:0] add_val;
    logic [14:0] sum;
    logic [13:0] secs_next;

    conv_state_t state;
    logic [13:0] src;
    logic [29:0] sh;
    logic [3:0]  cnt;

    assign btn_raw = {set_b, set_a, add_300, add_180, add_120, add_60};

`ifdef METER_BUTTON_SYNC_EN
    logic [5:0] btn_s1, btn_s2, btn_s3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            btn_s3 <= '0;
        end else begin
            btn_s1 <= btn_raw;
            btn_s2 <= btn_s1;
            btn_s3 <= btn_s2;
        end
    end

    assign btn_act = btn_s2 & ~btn_s3;
`else
    assign btn_act = btn_raw;
`endif

    assign strobe = tick_s & ~tick_d;
    assign dec    = strobe && (secs != 14'd0);

    always_comb begin
        add_val = 15'd0;
        if (btn_act[3])      add_val = 15'd300;
        else if (btn_act[2]) add_val = 15'd180;
        else if (btn_act[1]) add_val = 15'd120;
        else if (btn_act[0]) add_val = 15'd60;
    end

    // 15-bit intermediate so the sum saturates instead of wrapping
    assign sum = {1'b0, secs} + add_val - {14'd0, dec};

    always_comb begin
        secs_next = secs;
        if (btn_act[5])                secs_next = 14'(PRESET_B);
        else if (btn_act[4])           secs_next = 14'(PRESET_A);
        else if (sum > 15'(MAX_SECS))  secs_next = 14'(MAX_SECS);
        else                           secs_next = sum[13:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_s    <= 1'b0;
            tick_d    <= 1'b0;
            blink_s   <= 1'b0;
            secs      <= '0;
            expired   <= 1'b0;
            digits_on <= 1'b0;
        end else begin
            tick_s  <= tick_1hz;
            tick_d  <= tick_s;
            blink_s <= blink_lvl;
            secs    <= secs_next;
            expired <= (secs == 14'd0);
            if (secs == 14'd0)
                digits_on <= tick_s;
            else if (secs < 14'(LOW_THRESH))
                digits_on <= blink_s;
            else
                digits_on <= 1'b1;
        end
    end

    function automatic logic [29:0] dd_step(input logic [29:0] v);
        logic [29:0] t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            if (t[14+4*i +: 4] >= 4'd5)
                t[14+4*i +: 4] = t[14+4*i +: 4] + 4'd3;
        end
        return {t[28:0], 1'b0};
    endfunction

    // A change of secs mid-conversion drops the partial result; time_bcd holds its last good value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            src       <= '0;
            sh        <= '0;
            cnt       <= '0;
            time_bcd  <= '0;
            bcd_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (secs != src) begin
                        src       <= secs;
                        sh        <= {16'd0, secs};
                        cnt       <= 4'd13;
                        bcd_valid <= 1'b0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (secs != src) begin
                        state <= IDLE;
                    end else begin
                        sh <= dd_step(sh);
                        if (cnt == 4'd0)
                            state <= DONE;
                        else
                            cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (secs == src) begin
                        time_bcd  <= sh[29:14];
                        bcd_valid <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
